// File: rtl/ascon_pack.sv
// Shared ASCON definitions: permutation state type, 5-bit S-box table and
// the round constants used by the constant-addition layer.
package ascon_pack;

   localparam int WORDS     = 5;
   localparam int WORD_BITS = 64;

   // state[0] = x0 .. state[4] = x4, each a 64-bit word
   typedef logic [0:WORDS-1][WORD_BITS-1:0] type_state;

   // 5-bit S-box, index = {x0,x1,x2,x3,x4} of one column (x0 is the MSB)
   localparam logic [4:0] SBOX [0:31] = '{
      5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
      5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
      5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
      5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
   };

   // Round constants for p_C (12-round schedule); consumed by the neighbouring layer
   localparam logic [7:0] ROUND_CONST [0:11] = '{
      8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
      8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
   };

   function automatic logic [4:0] sbox_lookup(input logic [4:0] idx);
      return SBOX[idx];
   endfunction

endpackage

// File: rtl/ascon_substitution_sbox.sv
// One column of the ASCON substitution layer: pure combinational 5-bit LUT.
module ascon_substitution_sbox
   import ascon_pack::*;
(
   input  logic [4:0] idx,
   output logic [4:0] value
);

   assign value = sbox_lookup(idx);

endmodule

// File: rtl/ascon_substitution.sv
// ASCON substitution layer p_S: 64 independent column S-boxes across the
// 320-bit state, followed by a valid-qualified output register (1 cycle).
module ascon_substitution
   import ascon_pack::*;
(
   input  logic      clock_i,
   input  logic      resetb_i,
   input  logic      valid_i,
   input  type_state state_i,
   output type_state state_o,
   output logic      valid_o
);

   logic [4:0] col_in  [WORD_BITS];
   logic [4:0] col_out [WORD_BITS];
   type_state  sub_state;
   type_state  state_reg;
   logic       valid_reg;

   // One S-box per bit column; x0 forms the MSB of the lookup index
   generate
      for (genvar gi = 0; gi < WORD_BITS; gi++) begin : g_col
         assign col_in[gi] = {state_i[0][gi], state_i[1][gi], state_i[2][gi],
                              state_i[3][gi], state_i[4][gi]};
         ascon_substitution_sbox u_sbox (
            .idx   (col_in[gi]),
            .value (col_out[gi])
         );
      end
   endgenerate

   // Scatter each column result back into the five state words
   always_comb begin
      sub_state = '0;
      for (int i = 0; i < WORD_BITS; i++) begin
         sub_state[0][i] = col_out[i][4];
         sub_state[1][i] = col_out[i][3];
         sub_state[2][i] = col_out[i][2];
         sub_state[3][i] = col_out[i][1];
         sub_state[4][i] = col_out[i][0];
      end
   end

   // Output register: capture on valid, hold otherwise; reset drops any in-flight result
   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         state_reg <= '0;
         valid_reg <= 1'b0;
      end else begin
         valid_reg <= valid_i;
         if (valid_i) begin
            state_reg <= sub_state;
         end
      end
   end

   assign state_o = state_reg;
   assign valid_o = valid_reg;

endmodule

// File: tb/tb_ascon_substitution.sv
// Scoreboard bench for ascon_substitution: expected states come from a
// bit-sliced equation model and are queued at drive time, popped at output.
module tb_ascon_substitution;
   import ascon_pack::*;

   logic      clock_i = 1'b0;
   logic      resetb_i = 1'b1;
   logic      valid_i = 1'b0;
   type_state state_i = '0;
   type_state state_o;
   logic      valid_o;

   int        tests = 0;
   int        errors = 0;
   type_state exp_q [$];
   type_state last_out = '0;

   ascon_substitution dut (
      .clock_i  (clock_i),
      .resetb_i (resetb_i),
      .valid_i  (valid_i),
      .state_i  (state_i),
      .state_o  (state_o),
      .valid_o  (valid_o)
   );

   always #5 clock_i = ~clock_i;

   task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
      tests++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Bit-sliced ASCON S-box equations applied to whole words
   function automatic type_state ascon_model(input type_state s);
      logic [63:0] x [5];
      logic [63:0] t [5];
      type_state   r;
      for (int k = 0; k < 5; k++) x[k] = s[k];
      x[0] ^= x[4]; x[4] ^= x[3]; x[2] ^= x[1];
      for (int k = 0; k < 5; k++) t[k] = ~x[k] & x[(k + 1) % 5];
      for (int k = 0; k < 5; k++) x[k] ^= t[(k + 1) % 5];
      x[1] ^= x[0]; x[0] ^= x[4]; x[3] ^= x[2]; x[2] = ~x[2];
      for (int k = 0; k < 5; k++) r[k] = x[k];
      return r;
   endfunction

   function automatic type_state rand_state();
      type_state r;
      for (int k = 0; k < 5; k++) r[k] = {$urandom, $urandom};
      return r;
   endfunction

   // Drive one cycle, queue the expectation, then check just after the edge
   task automatic cycle(input string tag, input logic v, input type_state s);
      type_state e;
      valid_i = v;
      state_i = s;
      if (v) exp_q.push_back(ascon_model(s));
      @(posedge clock_i);
      #1;
      check({tag, "_valid"}, {319'd0, valid_o}, {319'd0, v});
      if (v) begin
         if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 320'd0, 320'd1);
         end else begin
            e = exp_q.pop_front();
            check({tag, "_state"}, state_o, e);
            last_out = e;
         end
      end else begin
         check({tag, "_hold"}, state_o, last_out);
      end
      $display("[TB] %s v=%0b out=%h", tag, v, state_o[0]);
   endtask

   type_state s;
   type_state ones;
   type_state vec;

   initial begin
      // 1: asynchronous reset, observed before the first clock edge
      valid_i = 1'b1;
      state_i = rand_state();
      #1 resetb_i = 1'b0;
      #1;
      check("rst_async_state", state_o, '0);
      check("rst_async_valid", {319'd0, valid_o}, 320'd0);
      repeat (2) begin
         state_i = rand_state();
         @(posedge clock_i); #1;
         check("rst_hold_state", state_o, '0);
         check("rst_hold_valid", {319'd0, valid_o}, 320'd0);
      end
      @(negedge clock_i);
      resetb_i = 1'b1;
      valid_i  = 1'b0;
      last_out = '0;

      // 2: all-zero state
      cycle("zero", 1'b1, '0);
      check("zero_const", state_o, {64'd0, 64'd0, {64{1'b1}}, 64'd0, 64'd0});

      // 3: all-ones state
      for (int k = 0; k < 5; k++) ones[k] = {64{1'b1}};
      cycle("ones", 1'b1, ones);
      check("ones_const", state_o, {{64{1'b1}}, 64'd0, {64{1'b1}}, {64{1'b1}}, {64{1'b1}}});

      // 4: single set bit in x0
      s = '0;
      s[0] = 64'h1;
      cycle("x0bit", 1'b1, s);
      check("x0bit_const", state_o, {64'h1, 64'h1, {64{1'b1}}, 64'h1, 64'h0});

      // 5: reference vector, then random stream with gaps
      vec[0] = 64'heeea8c8972cc93fd;
      vec[1] = 64'hff9e7f5bbb51cb2a;
      vec[2] = 64'hd043ab88a97926c5;
      vec[3] = 64'hf8bda5cbfdf4f6b4;
      vec[4] = 64'h221f7efb7af94591;
      cycle("vector", 1'b1, vec);
      for (int i = 0; i < 1000; i++) begin
         cycle("rand", ($urandom_range(0, 3) != 0), rand_state());
      end

      // 6: reset between two valid inputs
      cycle("pre_rst", 1'b1, rand_state());
      valid_i = 1'b1;
      state_i = rand_state();
      #1 resetb_i = 1'b0;
      #1;
      check("midrst_valid", {319'd0, valid_o}, 320'd0);
      check("midrst_state", state_o, '0);
      @(posedge clock_i); #1;
      check("midrst_lost_valid", {319'd0, valid_o}, 320'd0);
      check("midrst_lost_state", state_o, '0);
      @(negedge clock_i);
      resetb_i = 1'b1;
      last_out = '0;
      cycle("post_rst_idle", 1'b0, rand_state());
      cycle("post_rst", 1'b1, rand_state());
      cycle("post_rst2", 1'b1, vec);

      check("queue_empty", exp_q.size(), 320'd0);
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
